// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - requester and data-memory signal bundle for dm_arbiter
interface dm_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_din;
    logic              dm_we;
    logic [DATA_W-1:0] dm_dout;
    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  dm_dout,
        output ack0, rdata0, ack1, rdata1,
        output dm_addr, dm_din, dm_we, busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output dm_dout,
        input  ack0, rdata0, ack1, rdata1,
        input  dm_addr, dm_din, dm_we, busy
    );
endinterface

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port round-robin arbiter/sequencer for the data memory
module dm_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dm_arbiter_if.slave    bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state, state_n;
    logic              last, cur;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              we_q;
    logic              ack0_q, ack1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              elig0, elig1, grant, sel;

    always_comb begin
        // A port whose ack is high this cycle is still holding the old request.
        elig0   = bus.req0 & ~ack0_q;
        elig1   = bus.req1 & ~ack1_q;
        grant   = 1'b0;
        sel     = 1'b0;
        state_n = state;
        case (state)
            IDLE: begin
                grant = elig0 | elig1;
                sel   = (elig0 & elig1) ? ~last : elig1;
                if (grant) state_n = ACCESS;
            end
            ACCESS: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last     <= 1'b1;
            cur      <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            we_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            if (state == IDLE && grant) begin
                cur    <= sel;
                last   <= sel;
                addr_q <= sel ? bus.addr1  : bus.addr0;
                we_q   <= sel ? bus.we1    : bus.we0;
                din_q  <= sel ? bus.wdata1 : bus.wdata0;
            end else if (state == ACCESS) begin
                we_q <= 1'b0;
                // Writes echo the latched write data back to the requester.
                if (cur) begin
                    ack1_q   <= 1'b1;
                    rdata1_q <= we_q ? din_q : bus.dm_dout;
                end else begin
                    ack0_q   <= 1'b1;
                    rdata0_q <= we_q ? din_q : bus.dm_dout;
                end
            end
        end
    end

    assign bus.dm_addr = addr_q;
    assign bus.dm_din  = din_q;
    assign bus.dm_we   = we_q;
    assign bus.busy    = (state == ACCESS);
    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed self-checking bench for dm_arbiter
module tb_dm_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();
    dm_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] mem [0:1023];
    assign bus.dm_dout = mem[bus.dm_addr];
    always @(negedge clk) if (bus.dm_we) mem[bus.dm_addr] = bus.dm_din;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          port;
        bit          we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];
    logic [31:0] exp_r0, exp_r1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit port, input bit r, input bit we, input logic [9:0] a, input logic [31:0] d);
        if (port) begin bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
        else      begin bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Issue one request at posedge+1 and expect ack on the third negedge (cycle T+2).
    task automatic run_vec(input int i, input vec_t v);
        int  cyc;
        bit  seen;
        bit  ack_p, ack_o;
        @(posedge clk); #1;
        drive(v.port, 1, v.we, v.addr, v.wdata);
        cyc = 0; seen = 0;
        while (!seen && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                chk($sformatf("v%0d busy", i), {31'b0, bus.busy}, 32'd1);
                chk($sformatf("v%0d dm_addr", i), {22'b0, bus.dm_addr}, {22'b0, v.addr});
                chk($sformatf("v%0d dm_we", i), {31'b0, bus.dm_we}, {31'b0, v.we});
            end
            ack_p = v.port ? bus.ack1 : bus.ack0;
            ack_o = v.port ? bus.ack0 : bus.ack1;
            if (ack_o) chk($sformatf("v%0d other ack", i), 32'd1, 32'd0);
            if (ack_p) seen = 1;
        end
        chk($sformatf("v%0d ack latency", i), cyc, seen ? 32'd3 : 32'd99);
        if (v.port) exp_r1 = v.exp; else exp_r0 = v.exp;
        chk($sformatf("v%0d rdata0", i), bus.rdata0, exp_r0);
        chk($sformatf("v%0d rdata1", i), bus.rdata1, exp_r1);
        @(posedge clk); #1;
        drive(v.port, 0, 0, 0, 0);
    endtask

    initial begin
        int n0, n1, prev_port, last_neg, k, accesses;
        bit first;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h010] = 32'hDEADBEEF;
        mem[10'h001] = 32'h0000000A;
        mem[10'h002] = 32'h0000000B;
        mem[10'h005] = 32'h00000055;
        mem[10'h006] = 32'h00000066;
        mem[10'h020] = 32'h11112222;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        exp_r0 = 0; exp_r1 = 0;

        vecs[0] = '{port: 0, we: 0, addr: 10'h010, wdata: 32'h0,        exp: 32'hDEADBEEF};
        vecs[1] = '{port: 1, we: 1, addr: 10'h3FF, wdata: 32'h12345678, exp: 32'h12345678};
        vecs[2] = '{port: 0, we: 0, addr: 10'h3FF, wdata: 32'h0,        exp: 32'h12345678};
        vecs[3] = '{port: 1, we: 0, addr: 10'h001, wdata: 32'h0,        exp: 32'h0000000A};
        vecs[4] = '{port: 0, we: 1, addr: 10'h000, wdata: 32'h0BADF00D, exp: 32'h0BADF00D};
        vecs[5] = '{port: 1, we: 0, addr: 10'h000, wdata: 32'h0,        exp: 32'h0BADF00D};
        vecs[6] = '{port: 1, we: 0, addr: 10'h002, wdata: 32'h0,        exp: 32'h0000000B};
        vecs[7] = '{port: 0, we: 0, addr: 10'h3FF, wdata: 32'h0,        exp: 32'h12345678};

        // Reset values
        #2;
        chk("rst busy",    {31'b0, bus.busy},  32'd0);
        chk("rst dm_we",   {31'b0, bus.dm_we}, 32'd0);
        chk("rst acks",    {30'b0, bus.ack1, bus.ack0}, 32'd0);
        chk("rst dm_addr", {22'b0, bus.dm_addr}, 32'd0);
        chk("rst dm_din",  bus.dm_din, 32'd0);
        chk("rst rdata0",  bus.rdata0, 32'd0);
        chk("rst rdata1",  bus.rdata1, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
        chk("wb mem 3ff", mem[10'h3FF], 32'h12345678);

        // Ack masking: run_vec held req0 through its ack cycle; no further access may follow
        accesses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.busy) accesses++;
        end
        chk("mask no reissue", accesses, 32'd0);

        // Contention: both ports held, four reads each, strict alternation starting with port 0
        do_reset();
        @(posedge clk); #1;
        drive(0, 1, 0, 10'h001, 0);
        drive(1, 1, 0, 10'h002, 0);
        n0 = 0; n1 = 0; prev_port = 1; last_neg = -10; first = 1;
        for (int c = 0; c < 40 && (n0 + n1) < 8; c++) begin
            @(negedge clk);
            if (bus.ack0 && bus.ack1) chk("cont dual ack", 32'd1, 32'd0);
            if (bus.ack0 || bus.ack1) begin
                k = bus.ack1 ? 1 : 0;
                chk($sformatf("cont order %0d", n0 + n1), k, (prev_port == 0) ? 32'd1 : 32'd0);
                if (!first) chk($sformatf("cont gap %0d", n0 + n1), c - last_neg, 32'd2);
                first = 0;
                last_neg = c;
                prev_port = k;
                if (k == 0) begin
                    chk("cont rdata0", bus.rdata0, 32'h0000000A);
                    n0++;
                    if (n0 == 4) bus.req0 = 1'b0;
                end else begin
                    chk("cont rdata1", bus.rdata1, 32'h0000000B);
                    n1++;
                    if (n1 == 4) bus.req1 = 1'b0;
                end
            end
        end
        chk("cont count0", n0, 32'd4);
        chk("cont count1", n1, 32'd4);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (3) @(posedge clk);

        // Async reset in the middle of the ACCESS cycle, before the write negedge
        @(posedge clk); #1;
        drive(0, 1, 1, 10'h020, 32'hCAFEF00D);
        @(posedge clk); #1;
        chk("ar busy pre",  {31'b0, bus.busy},  32'd1);
        chk("ar dm_we pre", {31'b0, bus.dm_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar dm_we",   {31'b0, bus.dm_we}, 32'd0);
        chk("ar busy",    {31'b0, bus.busy},  32'd0);
        chk("ar dm_addr", {22'b0, bus.dm_addr}, 32'd0);
        chk("ar dm_din",  bus.dm_din, 32'd0);
        chk("ar rdata0",  bus.rdata0, 32'd0);
        drive(0, 0, 0, 0, 0);
        k = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.ack0) k++;
        end
        chk("ar no ack0", k, 32'd0);
        chk("ar mem 020", mem[10'h020], 32'h11112222);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Inputs changed after grant must not affect the latched transaction
        @(posedge clk); #1;
        drive(0, 1, 1, 10'h005, 32'h00005A5A);
        @(posedge clk); #1;
        bus.addr0 = 10'h006;
        bus.wdata0 = 32'hFFFFFFFF;
        @(negedge clk);
        chk("ic dm_addr", {22'b0, bus.dm_addr}, 32'h005);
        chk("ic dm_din",  bus.dm_din, 32'h00005A5A);
        @(negedge clk);
        chk("ic ack0",   {31'b0, bus.ack0}, 32'd1);
        chk("ic rdata0", bus.rdata0, 32'h00005A5A);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        chk("ic mem 005", mem[10'h005], 32'h00005A5A);
        chk("ic mem 006", mem[10'h006], 32'h00000066);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
